// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier, one Booth step per clock.
// Operands are widened to WIDTH+1 bits (sign- or zero-extended), so a single
// signed Booth datapath covers both signed and unsigned operations.
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips the Booth steps
// and the (zero) product appears one cycle after acceptance.
module booth_multiplier_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 step_add,
   output logic                 step_sub
);

   localparam int W1 = WIDTH + 1;
   localparam int CW = $clog2(W1 + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W1-1:0]     accA_q, accA_d;
   logic [W1-1:0]     regQ_q, regQ_d;
   logic              qMinus1_q, qMinus1_d;
   logic [W1-1:0]     regM_q, regM_d;
   logic [CW-1:0]     stepCnt_q, stepCnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic              outValid_q, outValid_d;

   logic [W1-1:0]     extM;
   logic [W1-1:0]     extQ;
   logic [W1-1:0]     sum;
   logic [W1-1:0]     shiftA;
   logic [W1-1:0]     shiftQ;
   logic              zeroOperand;

   // Widen operands, pick the Booth add/subtract and form the shifted {A,Q}.
   always_comb begin
      extM   = {is_signed & multiplicand[WIDTH-1], multiplicand};
      extQ   = {is_signed & multiplier[WIDTH-1], multiplier};
      sum    = accA_q;
      if ({regQ_q[0], qMinus1_q} == 2'b01) begin
         sum = accA_q + regM_q;
      end else if ({regQ_q[0], qMinus1_q} == 2'b10) begin
         sum = accA_q - regM_q;
      end
      shiftA = {sum[W1-1], sum[W1-1:1]};
      shiftQ = {sum[0], regQ_q[W1-1:1]};
`ifdef BOOTH_ZERO_BYPASS_EN
      zeroOperand = (multiplicand == '0) || (multiplier == '0);
`else
      zeroOperand = 1'b0;
`endif
   end

   // Debug strobes reflect the decode of the step happening this cycle; the
   // two decodes are mutually exclusive so the strobes can never overlap.
   always_comb begin
      step_add = (state_q == RUN) && ({regQ_q[0], qMinus1_q} == 2'b01);
      step_sub = (state_q == RUN) && ({regQ_q[0], qMinus1_q} == 2'b10);
   end

   // Next-state and datapath control; every register holds unless a state
   // below decides otherwise.
   always_comb begin
      state_d    = state_q;
      accA_d     = accA_q;
      regQ_d     = regQ_q;
      qMinus1_d  = qMinus1_q;
      regM_d     = regM_q;
      stepCnt_d  = stepCnt_q;
      product_d  = product_q;
      outValid_d = outValid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accA_d    = '0;
               qMinus1_d = 1'b0;
               state_d   = RUN;
               if (zeroOperand) begin
                  // A zero operand collapses to one do-nothing step: with M and
                  // Q cleared the decode is 00, so no strobes fire and the
                  // product is 0 one cycle later.
                  regM_d    = '0;
                  regQ_d    = '0;
                  stepCnt_d = CW'(1);
               end else begin
                  regM_d    = extM;
                  regQ_d    = extQ;
                  stepCnt_d = CW'(W1);
               end
            end
         end
         RUN: begin
            accA_d    = shiftA;
            regQ_d    = shiftQ;
            qMinus1_d = regQ_q[0];
            stepCnt_d = stepCnt_q - CW'(1);
            if (stepCnt_q == CW'(1)) begin
               product_d  = {shiftA[WIDTH-2:0], shiftQ};
               outValid_d = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight operation without output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         accA_q     <= '0;
         regQ_q     <= '0;
         qMinus1_q  <= 1'b0;
         regM_q     <= '0;
         stepCnt_q  <= '0;
         product_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         accA_q     <= accA_d;
         regQ_q     <= regQ_d;
         qMinus1_q  <= qMinus1_d;
         regM_q     <= regM_d;
         stepCnt_q  <= stepCnt_d;
         product_q  <= product_d;
         outValid_q <= outValid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = outValid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: table-driven vectors plus hand-written corner
// sequences for booth_multiplier_seq (WIDTH=16), with a result scoreboard.
module tb_booth_multiplier_seq;

   localparam int WIDTH = 16;
   localparam int W1 = WIDTH + 1;
   localparam int MAXWAIT = 100;

   logic                clk;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic                is_signed;
   logic [WIDTH-1:0]    multiplicand;
   logic [WIDTH-1:0]    multiplier;
   logic                out_valid;
   logic                out_ready;
   logic [2*WIDTH-1:0]  product;
   logic                step_add;
   logic                step_sub;

   int nTests;
   int nFail;
   logic [2*WIDTH-1:0] expQueue[$];

   typedef struct {
      logic              sgn;
      logic [WIDTH-1:0]  m;
      logic [WIDTH-1:0]  q;
      logic [2*WIDTH-1:0] exp;
   } vec_t;

   vec_t vecs[7];

   booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .is_signed(is_signed),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product(product),
      .step_add(step_add),
      .step_sub(step_sub)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference product from ordinary arithmetic on widened operands.
   function automatic logic [2*WIDTH-1:0] modelMul(input logic sgn,
                                                   input logic [WIDTH-1:0] m,
                                                   input logic [WIDTH-1:0] q);
      logic [2*WIDTH+1:0] a;
      logic [2*WIDTH+1:0] b;
      logic [2*WIDTH+1:0] r;
      a = sgn ? {{(WIDTH+2){m[WIDTH-1]}}, m} : {{(WIDTH+2){1'b0}}, m};
      b = sgn ? {{(WIDTH+2){q[WIDTH-1]}}, q} : {{(WIDTH+2){1'b0}}, q};
      r = a * b;
      return r[2*WIDTH-1:0];
   endfunction

   function automatic int expLatency(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
`ifdef BOOTH_ZERO_BYPASS_EN
      if (m == '0 || q == '0) return 1;
`endif
      return W1;
   endfunction

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Waits for IDLE, presents one operation for exactly the accepting edge and
   // pushes its expected product onto the scoreboard.
   task automatic applyStimulus(input logic sgn, input logic [WIDTH-1:0] m,
                                input logic [WIDTH-1:0] q, input logic [2*WIDTH-1:0] exp);
      int waitCnt;
      waitCnt = 0;
      while (!in_ready && waitCnt < MAXWAIT) begin
         stepClk();
         waitCnt++;
      end
      if (!in_ready) begin
         checkVal("in_ready_timeout", 64'(in_ready), 64'd1);
      end
      in_valid     = 1'b1;
      is_signed    = sgn;
      multiplicand = m;
      multiplier   = q;
      expQueue.push_back(exp);
      stepClk();
      in_valid     = 1'b0;
      multiplicand = ~m;
      multiplier   = ~q;
      is_signed    = ~sgn;
   endtask

   // Counts cycles from acceptance to out_valid while watching the strobes,
   // then compares latency, product and strobe behaviour and completes the
   // output handshake.
   task automatic checkOutput(input string name, input int expLat,
                              input logic expFirstSub, input logic expNoStrobes);
      int lat;
      int nStrobe;
      logic firstSub;
      logic both;
      logic [2*WIDTH-1:0] exp;
      lat = 0;
      nStrobe = 0;
      firstSub = 1'b0;
      both = 1'b0;
      while (!out_valid && lat < MAXWAIT) begin
         if (step_add && step_sub) both = 1'b1;
         if (step_add || step_sub) nStrobe++;
         if (lat == 0) firstSub = step_sub;
         stepClk();
         lat++;
      end
      if (!out_valid) begin
         checkVal({name, "_timeout"}, 64'(out_valid), 64'd1);
      end else begin
         exp = (expQueue.size() > 0) ? expQueue.pop_front() : '0;
         checkVal({name, "_product"}, 64'(product), 64'(exp));
         checkVal({name, "_latency"}, 64'(lat), 64'(expLat));
         checkVal({name, "_strobe_overlap"}, 64'(both), 64'd0);
         if (expFirstSub) checkVal({name, "_first_step_sub"}, 64'(firstSub), 64'd1);
         if (expNoStrobes) checkVal({name, "_strobe_count"}, 64'(nStrobe), 64'd0);
         out_ready = 1'b1;
         stepClk();
         out_ready = 1'b0;
         checkVal({name, "_valid_drop"}, 64'(out_valid), 64'd0);
         checkVal({name, "_ready_back"}, 64'(in_ready), 64'd1);
      end
   endtask

   initial begin
      logic [2*WIDTH-1:0] heldProduct;
      logic [WIDTH-1:0] rm;
      logic [WIDTH-1:0] rq;
      logic rs;
      int runCnt;

      nTests = 0;
      nFail = 0;
      vecs[0] = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
      vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
      vecs[3] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
      vecs[4] = '{1'b1, 16'h0005, 16'h0006, 32'h0000001E};
      vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
      vecs[6] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};

      reset = 1'b1;
      in_valid = 1'b0;
      is_signed = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      out_ready = 1'b0;
      stepClk();
      stepClk();
      reset = 1'b0;
      checkVal("reset_in_ready", 64'(in_ready), 64'd1);
      checkVal("reset_out_valid", 64'(out_valid), 64'd0);
      checkVal("reset_product", 64'(product), 64'd0);
      checkVal("reset_strobes", 64'({step_add, step_sub}), 64'd0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].sgn, vecs[i].m, vecs[i].q, vecs[i].exp);
         checkOutput($sformatf("vec%0d", i), expLatency(vecs[i].m, vecs[i].q),
                     (i == 0), (expLatency(vecs[i].m, vecs[i].q) == 1));
      end

      // Random operations with out_ready held high the whole time.
      for (int i = 0; i < 8; i++) begin
         rm = 16'($urandom);
         rq = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         out_ready = 1'b1;
         applyStimulus(rs, rm, rq, modelMul(rs, rm, rq));
         checkOutput($sformatf("rand%0d", i), expLatency(rm, rq), 1'b0, 1'b0);
      end

      // Backpressure: product holds and new requests are ignored while DONE.
      applyStimulus(1'b1, 16'h0003, 16'hFFFE, modelMul(1'b1, 16'h0003, 16'hFFFE));
      runCnt = 0;
      while (!out_valid && runCnt < MAXWAIT) begin
         stepClk();
         runCnt++;
      end
      heldProduct = product;
      checkVal("bp_product", 64'(heldProduct), 64'(expQueue.pop_front()));
      in_valid = 1'b1;
      is_signed = 1'b0;
      multiplicand = 16'h0002;
      multiplier = 16'h0002;
      for (int i = 0; i < 5; i++) begin
         stepClk();
         checkVal("bp_hold_product", 64'(product), 64'(heldProduct));
         checkVal("bp_hold_valid", 64'(out_valid), 64'd1);
         checkVal("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      stepClk();
      out_ready = 1'b0;
      checkVal("bp_release_valid", 64'(out_valid), 64'd0);
      checkVal("bp_release_ready", 64'(in_ready), 64'd1);
      stepClk();
      checkVal("bp_nothing_accepted", 64'(in_ready), 64'd1);

      // Reset in the middle of a run discards the operation.
      applyStimulus(1'b1, 16'h1234, 16'h4321, 32'h0);
      void'(expQueue.pop_back());
      for (int i = 0; i < 8; i++) stepClk();
      checkVal("mid_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      stepClk();
      reset = 1'b0;
      out_ready = 1'b0;
      checkVal("midreset_in_ready", 64'(in_ready), 64'd1);
      checkVal("midreset_out_valid", 64'(out_valid), 64'd0);
      checkVal("midreset_product", 64'(product), 64'd0);
      applyStimulus(1'b1, 16'd5, 16'd6, 32'h0000001E);
      checkOutput("after_reset", W1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
